// File: rtl/riscv_defs_pkg.sv
// Shared RV32I definitions used by the memory stage:
// datapath width, load/store funct3 codes and memory FSM states.
package riscv_defs;

    localparam int NB_WORD = 32;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load alignment: selects the addressed byte/half of a read word and
// sign- or zero-extends it. Ports: rdata, addr_lo, funct3 -> ext_data.
module load_extend
    import riscv_defs::*;
(
    input  logic [NB_WORD-1:0] rdata,
    input  logic [1:0]         addr_lo,
    input  logic [2:0]         funct3,
    output logic [NB_WORD-1:0] ext_data
);

    logic [NB_WORD-1:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        ext_data = shifted;
        case (funct3)
            LS_B:    ext_data = {{24{shifted[7]}}, shifted[7:0]};
            LS_H:    ext_data = {{16{shifted[15]}}, shifted[15:0]};
            LS_BU:   ext_data = {24'b0, shifted[7:0]};
            LS_HU:   ext_data = {16'b0, shifted[15:0]};
            default: ext_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I memory stage: one outstanding req/ack access, store formatting,
// load extension and upstream stall. Ports: EX/MEM inputs, dmem port, WB.
module mem_access_unit
    import riscv_defs::*;
(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [2:0]         i_funct3,
    input  logic [NB_WORD-1:0] i_alu_result,
    input  logic [NB_WORD-1:0] i_store_data,
    output logic               o_stall,
    output logic [NB_WORD-1:0] o_load_data,
    output logic               o_load_valid,
    output logic               o_misaligned,
    output logic               o_dmem_req,
    output logic               o_dmem_we,
    output logic [NB_WORD-1:0] o_dmem_addr,
    output logic [3:0]         o_dmem_be,
    output logic [NB_WORD-1:0] o_dmem_wdata,
    input  logic               i_dmem_ack,
    input  logic [NB_WORD-1:0] i_dmem_rdata
);

    mem_state_t         state;
    logic [2:0]         funct3_q;
    logic [1:0]         off_q;
    logic               legal;
    logic               aligned;
    logic               access_ok;
    logic               start;
    logic               misaligned_evt;
    logic [3:0]         be_next;
    logic [NB_WORD-1:0] wdata_next;
    logic [NB_WORD-1:0] ext_data;

    // A set write bit wins, so store legality applies when both are set.
    assign legal = i_mem_write ?
                   (i_funct3 inside {LS_B, LS_H, LS_W}) :
                   (i_funct3 inside {LS_B, LS_H, LS_W, LS_BU, LS_HU});

    always_comb begin
        aligned = 1'b1;
        case (i_funct3)
            LS_W:       aligned = (i_alu_result[1:0] == 2'b00);
            LS_H, LS_HU: aligned = ~i_alu_result[0];
            default:    aligned = 1'b1;
        endcase
    end

    assign access_ok = i_valid & (i_mem_read | i_mem_write) & legal;

    // Inputs are only looked at in IDLE: while BUSY the upstream
    // registers are frozen and still present the in-flight access.
    assign start = access_ok & aligned & (state == IDLE) & ~i_reset;
    assign misaligned_evt = access_ok & ~aligned & (state == IDLE);

    assign o_stall    = start | ((state == BUSY) & ~i_dmem_ack);
    assign o_dmem_req = (state == BUSY);

    always_comb begin
        be_next    = 4'b0000;
        wdata_next = i_store_data;
        if (i_mem_write) begin
            case (i_funct3[1:0])
                2'b00: begin
                    be_next    = 4'b0001 << i_alu_result[1:0];
                    wdata_next = {4{i_store_data[7:0]}};
                end
                2'b01: begin
                    be_next    = i_alu_result[1] ? 4'b1100 : 4'b0011;
                    wdata_next = {2{i_store_data[15:0]}};
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = i_store_data;
                end
            endcase
        end
    end

    load_extend u_load_extend (
        .rdata    (i_dmem_rdata),
        .addr_lo  (off_q),
        .funct3   (funct3_q),
        .ext_data (ext_data)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= IDLE;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_be    <= 4'b0000;
            o_dmem_wdata <= '0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            o_load_data  <= '0;
            o_load_valid <= 1'b0;
            o_misaligned <= 1'b0;
        end else begin
            o_load_valid <= 1'b0;
            o_misaligned <= misaligned_evt;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= BUSY;
                        o_dmem_we    <= i_mem_write;
                        o_dmem_addr  <= {i_alu_result[NB_WORD-1:2], 2'b00};
                        o_dmem_be    <= be_next;
                        o_dmem_wdata <= wdata_next;
                        funct3_q     <= i_funct3;
                        off_q        <= i_alu_result[1:0];
                    end
                end
                BUSY: begin
                    if (i_dmem_ack) begin
                        state <= IDLE;
                        if (!o_dmem_we) begin
                            o_load_data  <= ext_data;
                            o_load_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random
// instruction streams compared each cycle against a behavioural model.
module tb_mem_access_unit;
    import riscv_defs::*;

    logic        clk = 1'b0;
    logic        i_reset, i_valid, i_mem_read, i_mem_write;
    logic [2:0]  i_funct3;
    logic [31:0] i_alu_result, i_store_data;
    logic        o_stall, o_load_valid, o_misaligned;
    logic [31:0] o_load_data;
    logic        o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_funct3     (i_funct3),
        .i_alu_result (i_alu_result),
        .i_store_data (i_store_data),
        .o_stall      (o_stall),
        .o_load_data  (o_load_data),
        .o_load_valid (o_load_valid),
        .o_misaligned (o_misaligned),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_be    (o_dmem_be),
        .o_dmem_wdata (o_dmem_wdata),
        .i_dmem_ack   (i_dmem_ack),
        .i_dmem_rdata (i_dmem_rdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal_f(bit rd, bit wr, logic [2:0] f3);
        if (wr) return f3 inside {3'd0, 3'd1, 3'd2};
        if (rd) return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        return 1'b0;
    endfunction

    function automatic int size_f(logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit aligned_f(logic [2:0] f3, logic [31:0] a);
        return (a % size_f(f3)) == 0;
    endfunction

    function automatic bit start_f(bit v, bit rd, bit wr, logic [2:0] f3,
                                   logic [31:0] a);
        return v && legal_f(rd, wr, f3) && aligned_f(f3, a);
    endfunction

    function automatic logic [31:0] ext_f(logic [31:0] rdat, int off,
                                          logic [2:0] f3);
        int bytes;
        logic [31:0] v, mask;
        bytes = size_f(f3);
        v = rdat >> (8 * off);
        if (bytes >= 4) return v;
        mask = (32'h1 << (8 * bytes)) - 32'h1;
        v = v & mask;
        if (!f3[2] && v[8*bytes-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] wdata_f(logic [2:0] f3, logic [31:0] d);
        case (size_f(f3))
            1:       return {24'b0, d[7:0]} * 32'h01010101;
            2:       return {16'b0, d[15:0]} * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] be_f(logic [2:0] f3, logic [31:0] a);
        int m;
        m = ((1 << size_f(f3)) - 1) << (a % 4);
        return 4'(m);
    endfunction

    bit          mon_en = 0;
    bit          m_busy = 0, m_lv = 0, m_mis = 0;
    logic [31:0] m_ld = '0;
    bit          m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic [2:0]  m_f3;
    int          m_off;

    int          stall_cnt, req_cnt, lv_cnt, mis_cnt;
    logic [31:0] obs_ld, obs_addr, obs_wdata;
    logic [3:0]  obs_be;

    always @(negedge clk) begin
        if (mon_en) begin
            bit st, wr, acc, mis;
            wr  = i_mem_write;
            acc = i_valid && legal_f(i_mem_read, wr, i_funct3);
            st  = !m_busy && !i_reset &&
                  start_f(i_valid, i_mem_read, wr, i_funct3, i_alu_result);
            mis = !m_busy && acc && !aligned_f(i_funct3, i_alu_result);

            chk("stall", o_stall, st || (m_busy && !i_dmem_ack));
            chk("req", o_dmem_req, m_busy);
            if (m_busy) begin
                chk("we", o_dmem_we, m_we);
                chk("addr", o_dmem_addr, m_addr);
                if (m_we) begin
                    chk("be", o_dmem_be, m_be);
                    chk("wdata", o_dmem_wdata, m_wdata);
                end
            end
            chk("load_valid", o_load_valid, m_lv);
            chk("load_data", o_load_data, m_ld);
            chk("misaligned", o_misaligned, m_mis);

            if (o_stall) stall_cnt++;
            if (o_dmem_req) begin
                req_cnt++;
                obs_addr  = o_dmem_addr;
                obs_be    = o_dmem_be;
                obs_wdata = o_dmem_wdata;
            end
            if (o_load_valid) begin
                lv_cnt++;
                obs_ld = o_load_data;
            end
            if (o_misaligned) mis_cnt++;

            if (i_reset) begin
                m_busy = 0;
                m_lv   = 0;
                m_mis  = 0;
                m_ld   = '0;
            end else begin
                m_lv = m_busy && i_dmem_ack && !m_we;
                if (m_lv) m_ld = ext_f(i_dmem_rdata, m_off, m_f3);
                m_mis = mis;
                if (m_busy && i_dmem_ack) begin
                    m_busy = 0;
                end else if (st) begin
                    m_busy  = 1;
                    m_we    = wr;
                    m_addr  = i_alu_result & ~32'h3;
                    m_be    = be_f(i_funct3, i_alu_result);
                    m_wdata = wdata_f(i_funct3, i_store_data);
                    m_f3    = i_funct3;
                    m_off   = int'(i_alu_result[1:0]);
                end
            end
        end
    end

    task automatic clear_obs();
        stall_cnt = 0;
        req_cnt   = 0;
        lv_cnt    = 0;
        mis_cnt   = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns likewise.
    task automatic run_instr(input bit v, input bit rd, input bit wr,
                             input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, input int delay,
                             input logic [31:0] rdat, input bit noise);
        i_valid      = v;
        i_mem_read   = rd;
        i_mem_write  = wr;
        i_funct3     = f3;
        i_alu_result = a;
        i_store_data = d;
        i_dmem_ack   = 1'b0;
        if (start_f(v, rd, wr, f3, a)) begin
            next_cycle();
            repeat (delay) next_cycle();
            i_dmem_ack   = 1'b1;
            i_dmem_rdata = rdat;
            next_cycle();
        end else begin
            i_dmem_ack   = noise;
            i_dmem_rdata = rdat;
            next_cycle();
        end
        i_dmem_ack = 1'b0;
        i_valid    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_mem_read = 1'b0;
        i_mem_write = 1'b0;
        i_funct3 = 3'b000;
        i_alu_result = '0;
        i_store_data = '0;
        i_dmem_ack = 1'b0;
        i_dmem_rdata = '0;
        next_cycle();
        mon_en = 1;
        next_cycle();
        i_reset = 1'b0;
        chk("rst_stall", o_stall, 0);
        chk("rst_req", o_dmem_req, 0);
        chk("rst_we", o_dmem_we, 0);
        chk("rst_addr", o_dmem_addr, 0);
        chk("rst_be", o_dmem_be, 0);
        chk("rst_wdata", o_dmem_wdata, 0);
        chk("rst_ld", o_load_data, 0);
        chk("rst_lv", o_load_valid, 0);
        chk("rst_mis", o_misaligned, 0);

        clear_obs();
        run_instr(1, 0, 1, LS_W, 32'h100, 32'hDEADBEEF, 0, 0, 0);
        next_cycle();
        chk("sw_stall_cycles", stall_cnt, 1);
        chk("sw_req_cycles", req_cnt, 1);
        chk("sw_be", obs_be, 4'b1111);
        chk("sw_addr", obs_addr, 32'h100);
        chk("sw_wdata", obs_wdata, 32'hDEADBEEF);
        chk("sw_no_lv", lv_cnt, 0);

        run_instr(1, 0, 1, LS_B, 32'h203, 32'h000000A5, 1, 0, 0);
        next_cycle();
        chk("sb_be", obs_be, 4'b1000);
        chk("sb_wdata", obs_wdata, 32'hA5A5A5A5);
        chk("sb_addr", obs_addr, 32'h200);

        clear_obs();
        run_instr(1, 1, 0, LS_B, 32'h101, 0, 3, 32'h12348000, 0);
        next_cycle();
        chk("lb_stall_cycles", stall_cnt, 4);
        chk("lb_data", obs_ld, 32'hFFFFFF80);
        run_instr(1, 1, 0, LS_BU, 32'h101, 0, 0, 32'h12348000, 0);
        next_cycle();
        chk("lbu_data", obs_ld, 32'h00000080);
        run_instr(1, 1, 0, LS_H, 32'h102, 0, 0, 32'hBEEF0000, 0);
        next_cycle();
        chk("lh_data", obs_ld, 32'hFFFFBEEF);
        run_instr(1, 1, 0, LS_HU, 32'h102, 0, 2, 32'hBEEF0000, 0);
        next_cycle();
        chk("lhu_data", obs_ld, 32'h0000BEEF);

        clear_obs();
        run_instr(1, 1, 0, LS_W, 32'h102, 0, 0, 0, 0);
        next_cycle();
        chk("lw_mis_pulse", mis_cnt, 1);
        chk("lw_mis_req", req_cnt, 0);
        chk("lw_mis_stall", stall_cnt, 0);

        i_valid = 1; i_mem_read = 1; i_mem_write = 0;
        i_funct3 = LS_W; i_alu_result = 32'h104; i_dmem_ack = 0;
        next_cycle();
        next_cycle();
        i_reset = 1'b1;
        i_valid = 1'b0;
        next_cycle();
        i_reset = 1'b0;
        chk("rstbusy_req", o_dmem_req, 0);
        chk("rstbusy_stall", o_stall, 0);
        chk("rstbusy_lv", o_load_valid, 0);
        run_instr(1, 1, 0, LS_W, 32'h108, 0, 1, 32'h55AA1234, 0);
        next_cycle();
        chk("lw_after_rst", obs_ld, 32'h55AA1234);

        clear_obs();
        t0 = cyc;
        run_instr(1, 1, 0, LS_W, 32'h10, 0, 0, 32'hCAFEF00D, 0);
        run_instr(1, 0, 1, LS_W, 32'h14, 32'h01234567, 0, 0, 0);
        chk("b2b_cycles", cyc - t0, 4);
        next_cycle();
        chk("b2b_reqs", req_cnt, 2);
        chk("b2b_stalls", stall_cnt, 2);
        chk("b2b_ld", obs_ld, 32'hCAFEF00D);
        chk("b2b_addr", obs_addr, 32'h14);

        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(0, 3);
            run_instr($urandom_range(0, 9) != 0, op[0], op[1],
                      3'($urandom_range(0, 7)), $urandom, $urandom,
                      $urandom_range(0, 3), $urandom,
                      $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) next_cycle();
        end
        next_cycle();
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
